apb_cmd_master: RTL and testbench

Parametrised APB master that replaces the fixed-address, opcode-driven master. It takes transfers from a valid/ready command port with per-command address, data, direction and byte strobes. It drives a protocol-correct APB bus with wait-states, PSLVERR and a wait-state timeout, and returns read data and status on a one-cycle response pulse. It sits between a local controller (DMA, test sequencer) and the APB slave fabric.

---
 rtl/apb_cmd_master_if.sv | 49 ++++
 rtl/apb_cmd_master.sv | 155 +++++++++++++++
 tb/tb_apb_cmd_master.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_cmd_master_if.sv
// Command/response port plus APB bus signals of apb_cmd_master, grouped so the
// master and the slave-side environment share one bundle.
interface apb_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    // Command port
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strb;

    // Response port
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    // APB bus
    logic              P_selx;
    logic              P_enable;
    logic [ADDR_W-1:0] P_addr;
    logic              P_write;
    logic [DATA_W-1:0] P_wdata;
    logic [STRB_W-1:0] P_strb;
    logic [DATA_W-1:0] P_rdata;
    logic              P_ready;
    logic              P_slverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output P_selx, P_enable, P_addr, P_write, P_wdata, P_strb,
        input  P_rdata, P_ready, P_slverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  P_selx, P_enable, P_addr, P_write, P_wdata, P_strb,
        output P_rdata, P_ready, P_slverr
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB master fed by a valid/ready command port; runs SETUP/ACCESS with wait
// states, PSLVERR capture and an optional wait-state timeout, then pulses a response.
module apb_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input logic              P_clk,
    input logic              P_rst,
    apb_cmd_master_if.master bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam bit TIMEOUT_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0] pstrb_q, pstrb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic cmd_ready;
    logic accept;
    logic load;

    // A new command may enter while idle or in the same cycle the slave completes.
    assign cmd_ready = (state_q == ST_IDLE) || ((state_q == ST_ACCESS) && bus.P_ready);
    assign accept    = bus.cmd_valid && cmd_ready;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        load          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                load = accept;
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ST_ACCESS: begin
                if (bus.P_ready) begin
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = bus.P_slverr;
                    rsp_rdata_d   = pwrite_q ? '0 : bus.P_rdata;
                    rsp_timeout_d = 1'b0;
                    if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                    end
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    state_d       = ST_IDLE;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase

        // Capture the command; reads never present byte strobes on the bus.
        if (load) begin
            state_d   = ST_SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            paddr_d   = bus.cmd_addr;
            pwrite_d  = bus.cmd_write;
            pwdata_d  = bus.cmd_wdata;
            pstrb_d   = bus.cmd_write ? bus.cmd_strb : '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge P_clk or posedge P_rst) begin
        if (P_rst) begin
            state_q       <= ST_IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.P_selx      = psel_q;
    assign bus.P_enable    = penable_q;
    assign bus.P_addr      = paddr_q;
    assign bus.P_write     = pwrite_q;
    assign bus.P_wdata     = pwdata_q;
    assign bus.P_strb      = pstrb_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: a behavioural slave with byte memory,
// a reference memory model for expected responses, and a decoupled response monitor.
module tb_apb_cmd_master;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 8;

    logic P_clk = 1'b0;
    logic P_rst = 1'b0;

    apb_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_cmd_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .P_clk(P_clk),
        .P_rst(P_rst),
        .bus  (bus)
    );

    always #5 P_clk = ~P_clk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;   // ACCESS cycles with P_ready low before the slave answers
        logic        slverr;
    } plan_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    plan_t      slave_q[$];
    rsp_t       exp_q[$];
    logic [7:0] ref_mem[logic [31:0]];
    logic [7:0] slv_mem[logic [31:0]];

    int n_vec  = 0;
    int n_fail = 0;

    int          sel_run = 0, en_run = 0, last_sel_run = 0, last_en_run = 0;
    logic [15:0] sel_pat = '0, last_pat = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected response from the transfer rules, applied to a byte-addressed memory.
    function automatic rsp_t model(input plan_t p);
        rsp_t        r;
        logic [31:0] a;
        a = {p.addr[31:2], 2'b00};
        r.rdata = '0;
        r.err   = 1'b0;
        r.to    = 1'b0;
        if (p.waits >= TIMEOUT) begin
            r.err = 1'b1;
            r.to  = 1'b1;
        end else begin
            r.err = p.slverr;
            for (int i = 0; i < 4; i++) begin
                if (p.write) begin
                    if (!p.slverr && p.strb[i]) ref_mem[a + 32'(i)] = p.wdata[8*i +: 8];
                end else begin
                    r.rdata[8*i +: 8] = ref_mem.exists(a + 32'(i)) ? ref_mem[a + 32'(i)] : 8'h00;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] slv_read(input logic [31:0] addr);
        logic [31:0] d;
        logic [31:0] a;
        a = {addr[31:2], 2'b00};
        for (int i = 0; i < 4; i++)
            d[8*i +: 8] = slv_mem.exists(a + 32'(i)) ? slv_mem[a + 32'(i)] : 8'h00;
        return d;
    endfunction

    function automatic void slv_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] a;
        a = {addr[31:2], 2'b00};
        for (int i = 0; i < 4; i++)
            if (s[i]) slv_mem[a + 32'(i)] = d[8*i +: 8];
    endfunction

    // APB slave: follows the plan popped at each SETUP and checks the bus fields.
    initial begin : slave
        plan_t cur;
        int    wcnt;
        bit    active;
        active       = 1'b0;
        wcnt         = 0;
        bus.P_ready  = 1'b0;
        bus.P_slverr = 1'b0;
        bus.P_rdata  = '0;
        forever begin
            @(negedge P_clk);
            if (P_rst) begin
                active      = 1'b0;
                bus.P_ready = 1'b0;
            end else if (bus.P_selx && !bus.P_enable) begin
                bus.P_ready = 1'b0;
                if (slave_q.size() == 0) begin
                    active = 1'b0;
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_setup: SETUP seen with no command issued (t=%0t)", $time);
                end else begin
                    cur    = slave_q.pop_front();
                    active = 1'b1;
                    wcnt   = cur.waits;
                    check("setup_addr", bus.P_addr, cur.addr);
                    check("setup_write", bus.P_write, cur.write);
                    check("setup_strb", bus.P_strb, cur.write ? cur.strb : 4'h0);
                    if (cur.write) check("setup_wdata", bus.P_wdata, cur.wdata);
                end
            end else if (bus.P_selx && bus.P_enable && active) begin
                check("access_addr_stable", bus.P_addr, cur.addr);
                check("access_write_stable", bus.P_write, cur.write);
                check("access_strb_stable", bus.P_strb, cur.write ? cur.strb : 4'h0);
                if (cur.write) check("access_wdata_stable", bus.P_wdata, cur.wdata);
                if (wcnt == 0) begin
                    bus.P_ready  = 1'b1;
                    bus.P_slverr = cur.slverr;
                    bus.P_rdata  = cur.write ? $urandom : slv_read(cur.addr);
                    if (cur.write && !cur.slverr) slv_write(cur.addr, cur.wdata, cur.strb);
                end else begin
                    wcnt--;
                    bus.P_ready  = 1'b0;
                    bus.P_slverr = 1'($urandom);
                    bus.P_rdata  = $urandom;
                end
            end else begin
                bus.P_ready  = 1'b0;
                bus.P_slverr = 1'b0;
            end
        end
    end

    // Response monitor: pops one expectation per rsp_valid pulse; fields must hold otherwise.
    initial begin : monitor
        rsp_t e;
        rsp_t last;
        last.rdata = '0;
        last.err   = 1'b0;
        last.to    = 1'b0;
        forever begin
            @(negedge P_clk);
            if (P_rst) begin
                last.rdata = '0;
                last.err   = 1'b0;
                last.to    = 1'b0;
            end else if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", bus.rsp_rdata, e.rdata);
                    check("rsp_err", bus.rsp_err, e.err);
                    check("rsp_timeout", bus.rsp_timeout, e.to);
                end
                last.rdata = bus.rsp_rdata;
                last.err   = bus.rsp_err;
                last.to    = bus.rsp_timeout;
            end else begin
                check("rsp_hold_rdata", bus.rsp_rdata, last.rdata);
                check("rsp_hold_err", bus.rsp_err, last.err);
                check("rsp_hold_timeout", bus.rsp_timeout, last.to);
            end
        end
    end

    // Bus shape tracker: length of each PSEL burst and PENABLE pattern inside it.
    initial begin : tracker
        forever begin
            @(negedge P_clk);
            if (bus.P_selx) begin
                sel_run++;
                sel_pat = {sel_pat[14:0], bus.P_enable};
            end else if (sel_run > 0) begin
                last_sel_run = sel_run;
                last_pat     = sel_pat;
                sel_run      = 0;
                sel_pat      = '0;
            end
            if (bus.P_enable) begin
                en_run++;
            end else if (en_run > 0) begin
                last_en_run = en_run;
                en_run      = 0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic plan_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input int waits, input logic err);
        plan_t p;
        p.write = w; p.addr = a; p.wdata = d; p.strb = s; p.waits = waits; p.slverr = err;
        return p;
    endfunction

    task automatic issue(input plan_t p, input bit expect_rsp);
        bit accepted;
        @(negedge P_clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = p.write;
        bus.cmd_addr  = p.addr;
        bus.cmd_wdata = p.wdata;
        bus.cmd_strb  = p.strb;
        slave_q.push_back(p);
        if (expect_rsp) exp_q.push_back(model(p));
        accepted = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (bus.cmd_ready) begin
                @(posedge P_clk);
                accepted = 1'b1;
                break;
            end
            @(negedge P_clk);
        end
        if (!accepted) begin
            n_vec++;
            n_fail++;
            $display("FAIL cmd_accept: command at addr 0x%0h not accepted within 200 cycles", p.addr);
        end
    endtask

    task automatic idle(input int n);
        @(negedge P_clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_strb  = 4'($urandom);
        repeat (n - 1) @(negedge P_clk);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge P_clk);
            if (exp_q.size() == 0 && !bus.P_selx) begin
                done = 1'b1;
                break;
            end
        end
        @(negedge P_clk);
        if (!done) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: %0d responses still outstanding after 100 cycles", exp_q.size());
        end
    endtask

    initial begin : stimulus
        plan_t p;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;

        #1 P_rst = 1'b1;
        #1;
        check("reset_psel", bus.P_selx, 1'b0);
        check("reset_penable", bus.P_enable, 1'b0);
        check("reset_paddr", bus.P_addr, 32'h0);
        check("reset_pwrite", bus.P_write, 1'b0);
        check("reset_pwdata", bus.P_wdata, 32'h0);
        check("reset_pstrb", bus.P_strb, 4'h0);
        check("reset_rsp_valid", bus.rsp_valid, 1'b0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("reset_rsp_err", bus.rsp_err, 1'b0);
        check("reset_rsp_timeout", bus.rsp_timeout, 1'b0);
        check("reset_cmd_ready", bus.cmd_ready, 1'b1);
        repeat (3) @(negedge P_clk);
        #2 P_rst = 1'b0;

        // Single zero-wait write
        issue(mk(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0), 1'b1);
        idle(1);
        drain();
        check("single_write_psel_cycles", last_sel_run, 2);
        check("single_write_penable_cycles", last_en_run, 1);

        // Read with three wait states
        issue(mk(1'b0, 32'h10, 32'h0, 4'hF, 3, 1'b0), 1'b1);
        idle(1);
        drain();
        check("wait3_penable_cycles", last_en_run, 4);

        // Back-to-back: two writes then a read of the first
        issue(mk(1'b1, 32'h4, 32'h11, 4'hF, 0, 1'b0), 1'b1);
        issue(mk(1'b1, 32'h8, 32'h22, 4'hF, 0, 1'b0), 1'b1);
        issue(mk(1'b0, 32'h4, 32'h0, 4'h5, 0, 1'b0), 1'b1);
        idle(1);
        drain();
        check("b2b_psel_cycles", last_sel_run, 6);
        check("b2b_penable_pattern", last_pat, 16'b010101);

        // Slave error on a read
        issue(mk(1'b0, 32'h1C, 32'h0, 4'h0, 0, 1'b1), 1'b1);
        idle(1);
        drain();
        check("slverr_psel_cycles", last_sel_run, 2);
        check("slverr_back_idle", bus.cmd_ready, 1'b1);

        // Timeout: slave never answers
        issue(mk(1'b0, 32'h30, 32'h0, 4'h0, 1000, 1'b0), 1'b1);
        idle(1);
        drain();
        check("timeout_penable_cycles", last_en_run, TIMEOUT);
        check("timeout_psel_cycles", last_sel_run, TIMEOUT + 1);
        issue(mk(1'b1, 32'h20, 32'hCAFEF00D, 4'h3, 1, 1'b0), 1'b1);
        issue(mk(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0), 1'b1);
        idle(1);
        drain();

        // Randomized traffic: mixed gaps, wait states, errors and timeouts
        for (int n = 0; n < 300; n++) begin
            p.write  = 1'($urandom);
            p.addr   = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            p.wdata  = $urandom;
            p.strb   = 4'($urandom);
            p.waits  = ($urandom_range(0, 9) < 5) ? 0 : $urandom_range(1, 5);
            p.slverr = ($urandom_range(0, 7) == 0);
            issue(p, 1'b1);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
        drain();

        // Reset during an ACCESS wait state
        issue(mk(1'b0, 32'h8, 32'h0, 4'h0, 1000, 1'b0), 1'b0);
        idle(1);
        for (int i = 0; i < 20 && !bus.P_enable; i++) @(negedge P_clk);
        @(negedge P_clk);
        check("pre_reset_in_access", bus.P_enable, 1'b1);
        #2 P_rst = 1'b1;
        #1;
        check("midreset_psel", bus.P_selx, 1'b0);
        check("midreset_penable", bus.P_enable, 1'b0);
        @(negedge P_clk);
        check("midreset_no_rsp", bus.rsp_valid, 1'b0);
        #2 P_rst = 1'b0;
        #1;
        check("post_reset_cmd_ready", bus.cmd_ready, 1'b1);
        repeat (2) @(negedge P_clk);
        check("post_reset_no_rsp", bus.rsp_valid, 1'b0);
        issue(mk(1'b1, 32'h3C, 32'h89ABCDEF, 4'hF, 0, 1'b0), 1'b1);
        issue(mk(1'b0, 32'h3C, 32'h0, 4'h0, 2, 1'b0), 1'b1);
        idle(1);
        drain();
        check("final_queues_empty", exp_q.size() + slave_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
